// File: rtl/arbitro_botoes.sv
// Push-button front end: synchronises and debounces active-low pins, turns each
// release into a pending event and offers pending events round-robin on valid/ready.
module arbitro_botoes #(
    parameter int unsigned N_BOTOES        = 4,
    parameter int unsigned DEBOUNCE_CICLOS = 500000,
    localparam int unsigned ID_W           = $clog2(N_BOTOES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] botoes_n,
    output logic                evento_valid,
    output logic [ID_W-1:0]     evento_id,
    input  logic                evento_ready,
    output logic                perdido
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    typedef enum logic {
        OCIOSO,
        OFERTA
    } estado_t;

    estado_t             estado;
    logic [N_BOTOES-1:0] s1;
    logic [N_BOTOES-1:0] s2;
    logic [N_BOTOES-1:0] estavel;
    logic [CNT_W-1:0]    cnt [N_BOTOES];
    logic [N_BOTOES-1:0] pendente;
    logic [ID_W-1:0]     ultimo;

    logic [N_BOTOES-1:0] solto_c;
    logic [N_BOTOES-1:0] limpa_c;
    logic                achou_c;
    logic [ID_W-1:0]     escolhido_c;

    // Two-stage synchroniser; idle level of an active-low pin is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= botoes_n;
            s2 <= s1;
        end
    end

    // A changed level must survive DEBOUNCE_CICLOS consecutive samples to be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            estavel <= '1;
            for (int i = 0; i < int'(N_BOTOES); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_BOTOES); i++) begin
                if (s2[i] == estavel[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    estavel[i] <= s2[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Release edge: stable level is about to go 0 -> 1 on this clock.
    always_comb begin
        solto_c = '0;
        for (int i = 0; i < int'(N_BOTOES); i++) begin
            solto_c[i] = ~estavel[i] & s2[i] & (cnt[i] == CNT_MAX);
        end
    end

    assign limpa_c = (evento_valid && evento_ready) ? (N_BOTOES'(1) << evento_id) : '0;

    // Round-robin pick: first pending bit after the last served button, wrapping.
    always_comb begin
        int unsigned     pos;
        logic [ID_W-1:0] idx;
        achou_c     = 1'b0;
        escolhido_c = '0;
        pos         = 0;
        idx         = '0;
        for (int unsigned k = 1; k <= N_BOTOES; k++) begin
            pos = (32'(ultimo) + k) % N_BOTOES;
            idx = ID_W'(pos);
            if (!achou_c && pendente[idx]) begin
                achou_c     = 1'b1;
                escolhido_c = idx;
            end
        end
    end

    // Pending bits plus the offer FSM; a new event on a pending button is reported as lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado       <= OCIOSO;
            pendente     <= '0;
            ultimo       <= ID_W'(N_BOTOES - 1);
            evento_valid <= 1'b0;
            evento_id    <= '0;
            perdido      <= 1'b0;
        end else begin
            pendente <= (pendente & ~limpa_c) | solto_c;
            perdido  <= |(solto_c & pendente & ~limpa_c);
            case (estado)
                OCIOSO: begin
                    if (achou_c) begin
                        evento_id    <= escolhido_c;
                        evento_valid <= 1'b1;
                        estado       <= OFERTA;
                    end
                end
                OFERTA: begin
                    if (evento_ready) begin
                        ultimo       <= evento_id;
                        evento_valid <= 1'b0;
                        estado       <= OCIOSO;
                    end
                end
                default: begin
                    evento_valid <= 1'b0;
                    estado       <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_botoes.sv
// Bench for arbitro_botoes: directed scenarios plus random pin/ready traffic,
// checked every cycle against a window-based behavioural model.
module tb_arbitro_botoes;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] botoes_n = '1;
    logic         evento_ready = 1'b0;
    logic         evento_valid;
    logic [1:0]   evento_id;
    logic         perdido;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_perd   = 0;
    bit chk_en   = 1'b0;
    int acc_id  [$];
    int acc_cyc [$];

    always #5 clk = ~clk;

    arbitro_botoes #(.N_BOTOES(N), .DEBOUNCE_CICLOS(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .botoes_n     (botoes_n),
        .evento_valid (evento_valid),
        .evento_id    (evento_id),
        .evento_ready (evento_ready),
        .perdido      (perdido)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a level is accepted once the last D synchronised samples all disagree with it.
    logic [N-1:0] m_hist [0:D];
    logic [N-1:0] m_est;
    logic [N-1:0] m_pend;
    bit           m_valid;
    bit           m_perd;
    int           m_id;
    int           m_ultimo;

    always @(posedge clk) begin
        logic [N-1:0] solto;
        logic [N-1:0] limpa;
        logic [N-1:0] old_pend;
        bit           flip;
        bit           found;
        int           j;
        cyc++;
        if (rst) begin
            for (int k = 0; k <= D; k++) m_hist[k] = '1;
            m_est    = '1;
            m_pend   = '0;
            m_valid  = 1'b0;
            m_perd   = 1'b0;
            m_id     = 0;
            m_ultimo = N - 1;
        end else begin
            solto = '0;
            for (int i = 0; i < N; i++) begin
                flip = 1'b1;
                for (int k = 1; k <= D; k++) if (m_hist[k][i] == m_est[i]) flip = 1'b0;
                if (flip) begin
                    if (!m_est[i]) solto[i] = 1'b1;
                    m_est[i] = ~m_est[i];
                end
            end
            limpa    = '0;
            if (m_valid && evento_ready) limpa[m_id] = 1'b1;
            m_perd   = |(solto & m_pend & ~limpa);
            old_pend = m_pend;
            m_pend   = (m_pend & ~limpa) | solto;
            if (!m_valid) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    j = (m_ultimo + k) % N;
                    if (!found && old_pend[j]) begin
                        found   = 1'b1;
                        m_id    = j;
                        m_valid = 1'b1;
                    end
                end
            end else if (evento_ready) begin
                m_valid  = 1'b0;
                m_ultimo = m_id;
            end
            for (int k = D; k >= 1; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = botoes_n;
        end
    end

    // Transaction and loss monitor.
    always @(posedge clk) begin
        if (!rst && evento_valid && evento_ready) begin
            acc_id.push_back(int'(evento_id));
            acc_cyc.push_back(cyc);
        end
        if (!rst && perdido) n_perd++;
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", int'(evento_valid), int'(m_valid));
            check("perdido", int'(perdido), int'(m_perd));
            if (m_valid) check("id", int'(evento_id), m_id);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [N-1:0] mask, input int low);
        botoes_n = botoes_n & ~mask;
        tick(low);
        botoes_n = botoes_n | mask;
    endtask

    // Cycles from a release (already applied) until evento_valid is seen, bounded.
    task automatic latency(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!evento_valid && lat < 40);
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (evento_valid) seen++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen, n0, p0;
        int dur [N];

        tick(1);
        chk_en = 1'b1;
        check("rst_valid", int'(evento_valid), 0);
        check("rst_id", int'(evento_id), 0);
        check("rst_perdido", int'(perdido), 0);
        tick(2);
        rst = 1'b0;
        evento_ready = 1'b1;
        tick(5);

        // 1: held press on pin 2, event 7 cycles after release
        n0 = acc_id.size(); p0 = n_perd;
        botoes_n[2] = 1'b0;
        tick(10);
        botoes_n[2] = 1'b1;
        latency(lat);
        check("t1_latency", lat, 7);
        check("t1_model_latency", int'(m_valid), 1);
        check("t1_id", int'(evento_id), 2);
        tick(1);
        check("t1_valid_drop", int'(evento_valid), 0);
        tick(15);
        check("t1_events", acc_id.size() - n0, 1);
        if (acc_id.size() > n0) check("t1_acc_id", acc_id[n0], 2);
        check("t1_perdido", n_perd - p0, 0);

        // 2: 3-cycle glitch is filtered
        n0 = acc_id.size();
        press(4'b0010, 3);
        count_valid(20, seen);
        check("t2_no_valid", seen, 0);
        check("t2_events", acc_id.size() - n0, 0);

        // 3: simultaneous releases served round-robin from ultimo
        press(4'b0010, 6);
        tick(15);
        n0 = acc_id.size();
        press(4'b1010, 6);
        tick(15);
        check("t3a_events", acc_id.size() - n0, 2);
        if (acc_id.size() >= n0 + 2) begin
            check("t3a_first", acc_id[n0], 3);
            check("t3a_second", acc_id[n0+1], 1);
            check("t3a_gap", acc_cyc[n0+1] - acc_cyc[n0], 2);
        end
        press(4'b1000, 6);
        tick(15);
        n0 = acc_id.size();
        press(4'b1010, 6);
        tick(15);
        check("t3b_events", acc_id.size() - n0, 2);
        if (acc_id.size() >= n0 + 2) begin
            check("t3b_first", acc_id[n0], 1);
            check("t3b_second", acc_id[n0+1], 3);
            check("t3b_gap", acc_cyc[n0+1] - acc_cyc[n0], 2);
        end

        // 4: held offer, second press of the same button is lost
        evento_ready = 1'b0;
        n0 = acc_id.size(); p0 = n_perd;
        press(4'b0001, 6);
        latency(lat);
        check("t4_offer_id", int'(evento_id), 0);
        press(4'b0001, 6);
        tick(30 - 6);
        check("t4_hold_valid", int'(evento_valid), 1);
        check("t4_hold_id", int'(evento_id), 0);
        check("t4_perdido", n_perd - p0, 1);
        evento_ready = 1'b1;
        tick(15);
        check("t4_events", acc_id.size() - n0, 1);
        if (acc_id.size() > n0) check("t4_acc_id", acc_id[n0], 0);

        // 5: reset while offering drops everything
        evento_ready = 1'b0;
        press(4'b1010, 6);
        latency(lat);
        check("t5_offered", int'(evento_valid), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_valid_after_rst", int'(evento_valid), 0);
        evento_ready = 1'b1;
        n0 = acc_id.size();
        count_valid(25, seen);
        check("t5_no_valid", seen, 0);
        check("t5_events", acc_id.size() - n0, 0);

        // 6: long hold, nothing until release
        botoes_n[0] = 1'b0;
        count_valid(100, seen);
        check("t6_hold_quiet", seen, 0);
        botoes_n[0] = 1'b1;
        latency(lat);
        check("t6_latency", lat, 7);
        check("t6_id", int'(evento_id), 0);
        tick(10);

        // Random pins, ready and one reset, checked against the model.
        for (int i = 0; i < N; i++) dur[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (dur[i] == 0) begin
                    botoes_n[i] = 1'($urandom_range(0, 1));
                    dur[i] = int'($urandom_range(1, 12));
                end else begin
                    dur[i]--;
                end
            end
            evento_ready = (c % 400 < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
            rst = (c == 1700);
        end
        rst = 1'b0;
        botoes_n = '1;
        evento_ready = 1'b1;
        tick(30);
        check("end_idle", int'(evento_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
